// File: rtl/seg_scan_controller.sv
// Multiplexed seven-segment display controller: binary-to-BCD conversion,
// decimal/BCD/hex rendering, digit scanning with PWM brightness and blink.
module seg_scan_controller #(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BRIGHT_W     = 3,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [1:0]              mode,
  input  logic [DATA_W-1:0]       value,
  input  logic [4*N_DIGITS-1:0]   bcd_in,
  input  logic                    error,
  input  logic                    blink_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic                    busy,
  output logic [6:0]              seg_out,
  output logic [N_DIGITS-1:0]     an_out
);

  localparam int unsigned BCD_D  = DATA_W / 3 + 1;
  localparam int unsigned MAXD   = (BCD_D > N_DIGITS) ? BCD_D : N_DIGITS;
  localparam int unsigned SH_W   = 4 * BCD_D + DATA_W;
  localparam int unsigned PS_W   = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = $clog2(N_DIGITS);
  localparam int unsigned FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned DUTY_W = BRIGHT_W + $clog2(SCAN_DIV + 1) + 1;

  // Glyph codes 0..15 are hex digits; the rest are symbols.
  localparam logic [4:0] G_E     = 5'd14;
  localparam logic [4:0] G_MINUS = 5'd16;
  localparam logic [4:0] G_R     = 5'd17;
  localparam logic [4:0] G_BLANK = 5'd18;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [4*BCD_D-1:0]             bcd_q, bcd_d, adj_c, bcd_next_c;
  logic [DATA_W-1:0]              bin_q, bin_d, bin_next_c, mag_c;
  logic                           sign_q, sign_d, busy_d;
  logic [SH_W-1:0]                sh_c;
  logic [N_DIGITS-1:0][4:0]       frame_q, frame_d, dec_frame_c, direct_frame_c;
  logic [4*MAXD-1:0]              bcd_pad_c;
  logic [4*N_DIGITS-1:0]          hex_c;

  logic [PS_W-1:0]                presc_q;
  logic [IDX_W-1:0]               idx_q;
  logic [FC_W-1:0]                fc_q;
  logic                           blink_q;
  logic [DUTY_W-1:0]              duty_c;
  logic                           en_c;
  logic [4:0]                     glyph_c;
  logic [6:0]                     seg_c;
  logic [N_DIGITS-1:0]            an_c;

  function automatic logic [6:0] glyph_seg(input logic [4:0] g);
    case (g)
      5'd0:    glyph_seg = 7'h40;
      5'd1:    glyph_seg = 7'h79;
      5'd2:    glyph_seg = 7'h24;
      5'd3:    glyph_seg = 7'h30;
      5'd4:    glyph_seg = 7'h19;
      5'd5:    glyph_seg = 7'h12;
      5'd6:    glyph_seg = 7'h02;
      5'd7:    glyph_seg = 7'h78;
      5'd8:    glyph_seg = 7'h00;
      5'd9:    glyph_seg = 7'h10;
      5'd10:   glyph_seg = 7'h08;
      5'd11:   glyph_seg = 7'h03;
      5'd12:   glyph_seg = 7'h46;
      5'd13:   glyph_seg = 7'h21;
      5'd14:   glyph_seg = 7'h06;
      5'd15:   glyph_seg = 7'h0E;
      G_MINUS: glyph_seg = 7'h3F;
      G_R:     glyph_seg = 7'h2F;
      default: glyph_seg = 7'h7F;
    endcase
  endfunction

  // Magnitude of the signed input; the most negative value maps to 2^(DATA_W-1).
  assign mag_c = value[DATA_W-1] ? (~value + DATA_W'(1)) : value;

  // One double-dabble step: add 3 to digits >= 5, then shift the whole register.
  always_comb begin
    for (int i = 0; i < int'(BCD_D); i++) begin
      adj_c[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    sh_c       = {adj_c, bin_q} << 1;
    bcd_next_c = sh_c[SH_W-1 -: 4*BCD_D];
    bin_next_c = sh_c[DATA_W-1:0];
  end

  // Decimal rendering with leading-zero suppression, sign and overflow.
  always_comb begin
    int msd;
    int need;
    bcd_pad_c = (4*MAXD)'(bcd_next_c);
    msd = 0;
    for (int i = 0; i < int'(MAXD); i++) begin
      if (bcd_pad_c[4*i +: 4] != 4'd0) msd = i;
    end
    need = msd + 1 + (sign_q ? 1 : 0);
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (need > int'(N_DIGITS))  dec_frame_c[i] = G_MINUS;
      else if (i <= msd)          dec_frame_c[i] = {1'b0, bcd_pad_c[4*i +: 4]};
      else if (sign_q && i == msd + 1) dec_frame_c[i] = G_MINUS;
      else                        dec_frame_c[i] = G_BLANK;
    end
  end

  // Raw BCD, hex and blank modes render straight from the inputs.
  always_comb begin
    hex_c = (4*N_DIGITS)'(value);
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      case (mode)
        2'b01:   direct_frame_c[i] = (bcd_in[4*i +: 4] > 4'd9) ? G_BLANK : {1'b0, bcd_in[4*i +: 4]};
        2'b10:   direct_frame_c[i] = {1'b0, hex_c[4*i +: 4]};
        default: direct_frame_c[i] = G_BLANK;
      endcase
    end
  end

  // Load/convert FSM: next state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    sign_d  = sign_q;
    busy_d  = busy;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          if (mode == 2'b00) begin
            state_d = S_CONV;
            busy_d  = 1'b1;
            cnt_d   = '0;
            bcd_d   = '0;
            bin_d   = mag_c;
            sign_d  = value[DATA_W-1];
          end else begin
            frame_d = direct_frame_c;
          end
        end
      end
      S_CONV: begin
        bcd_d = bcd_next_c;
        bin_d = bin_next_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          frame_d = dec_frame_c;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      sign_q  <= 1'b0;
      busy    <= 1'b0;
      frame_q <= {N_DIGITS{G_BLANK}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      sign_q  <= sign_d;
      busy    <= busy_d;
      frame_q <= frame_d;
    end
  end

  // Scan timing: prescaler -> digit index -> frame counter -> blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      fc_q    <= '0;
      blink_q <= 1'b0;
    end else if (presc_q == PS_W'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      if (idx_q == IDX_W'(N_DIGITS - 1)) begin
        idx_q <= '0;
        if (fc_q == FC_W'(BLINK_FRAMES - 1)) begin
          fc_q    <= '0;
          blink_q <= ~blink_q;
        end else begin
          fc_q <= fc_q + FC_W'(1);
        end
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end else begin
      presc_q <= presc_q + PS_W'(1);
    end
  end

  // Current digit glyph, PWM/blink gating and anode select.
  always_comb begin
    duty_c = DUTY_W'(((DUTY_W'(brightness) + DUTY_W'(1)) * DUTY_W'(SCAN_DIV)) >> BRIGHT_W);
    en_c   = (DUTY_W'(presc_q) < duty_c) && !(blink_en && blink_q);
    if (error) begin
      if (32'(idx_q) == 32'd2)     glyph_c = G_E;
      else if (32'(idx_q) < 32'd2) glyph_c = G_R;
      else                         glyph_c = G_BLANK;
    end else begin
      glyph_c = frame_q[idx_q];
    end
    seg_c = en_c ? glyph_seg(glyph_c) : 7'h7F;
    an_c  = en_c ? ~(N_DIGITS'(1) << idx_q) : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= 7'h7F;
      an_out  <= '1;
    end else begin
      seg_out <= seg_c;
      an_out  <= an_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller: frame contents observed through the
// scanned outputs, plus busy timing, error overlay, PWM, blink and reset.
module tb_seg_scan_controller;

  localparam int unsigned N_DIGITS     = 8;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned SCAN_DIV     = 8;
  localparam int unsigned BRIGHT_W     = 3;
  localparam int unsigned BLINK_FRAMES = 2;

  logic        clk = 1'b0;
  logic        rst_n, load, error, blink_en, busy;
  logic [1:0]  mode;
  logic [15:0] value;
  logic [31:0] bcd_in;
  logic [2:0]  brightness;
  logic [6:0]  seg_out;
  logic [7:0]  an_out;

  int checks = 0;
  int errors = 0;

  typedef logic [7:0][6:0] frame_t;
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] value;
    logic [31:0] bcd;
    frame_t      exp;
  } vec_t;

  always #5 clk = ~clk;

  seg_scan_controller #(
    .N_DIGITS(N_DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV),
    .BRIGHT_W(BRIGHT_W), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .mode(mode), .value(value),
    .bcd_in(bcd_in), .error(error), .blink_en(blink_en), .brightness(brightness),
    .busy(busy), .seg_out(seg_out), .an_out(an_out)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_load(input logic [1:0] m, input logic [15:0] v, input logic [31:0] b);
    mode = m; value = v; bcd_in = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " busy_done"}, 32'(busy), 32'd0);
  endtask

  // Watch one full scan frame and record the glyph shown on each anode.
  task automatic check_frame(input string tag, input frame_t exp);
    frame_t f = '1;
    logic [7:0] seen = '0;
    int multi = 0;
    @(negedge clk);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (an_out != 8'hFF) begin
        if ($countones(~an_out) != 1) multi++;
        for (int d = 0; d < 8; d++) begin
          if (!an_out[d]) begin
            f[d] = seg_out;
            seen[d] = 1'b1;
          end
        end
      end
    end
    check({tag, " seen"}, 32'(seen), 32'hFF);
    check({tag, " onehot"}, 32'(multi), 32'd0);
    for (int d = 0; d < 8; d++) check($sformatf("%s d%0d", tag, d), 32'(f[d]), 32'(exp[d]));
  endtask

  function automatic logic [6:0] err_glyph(input int d);
    if (d == 2) return 7'h06;
    if (d < 2)  return 7'h2F;
    return 7'h7F;
  endfunction

  function automatic int digit_of(input logic [7:0] an);
    for (int d = 0; d < 8; d++) if (!an[d]) return d;
    return -1;
  endfunction

  vec_t vecs[11];

  initial begin
    int nb, d, on_cnt, run, max_off;
    int cnt[8];
    frame_t f123, fclk, ferr, blank;

    blank = {8{7'h7F}};
    f123  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30};
    fclk  = {7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h40, 7'h19, 7'h12};
    ferr  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h2F, 7'h2F};

    vecs[0]  = '{2'b00, 16'd123,  32'h0, f123};
    vecs[1]  = '{2'b00, 16'hFFD3, 32'h0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h19, 7'h12}};
    vecs[2]  = '{2'b00, 16'h8000, 32'h0, {7'h7F, 7'h7F, 7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00}};
    vecs[3]  = '{2'b00, 16'd0,    32'h0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[4]  = '{2'b00, 16'hFFFF, 32'h0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h79}};
    vecs[5]  = '{2'b00, 16'd32767, 32'h0, {7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h78}};
    vecs[6]  = '{2'b00, 16'd1000, 32'h0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40}};
    vecs[7]  = '{2'b01, 16'd0, 32'h00123045, fclk};
    vecs[8]  = '{2'b01, 16'd0, 32'hFA987654, {7'h7F, 7'h7F, 7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19}};
    vecs[9]  = '{2'b10, 16'h1A2F, 32'h0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h08, 7'h24, 7'h0E}};
    vecs[10] = '{2'b11, 16'd5, 32'h0, blank};

    rst_n = 1'b0; load = 1'b0; mode = 2'b00; value = '0; bcd_in = '0;
    error = 1'b0; blink_en = 1'b0; brightness = 3'd7;
    repeat (3) @(negedge clk);
    check("rst seg", 32'(seg_out), 32'h7F);
    check("rst an", 32'(an_out), 32'hFF);
    check("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    check_frame("rst frame", blank);

    // Table-driven loads.
    for (int i = 0; i < 11; i++) begin
      do_load(vecs[i].mode, vecs[i].value, vecs[i].bcd);
      if (vecs[i].mode == 2'b00) wait_idle($sformatf("vec%0d", i));
      else check($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
      check_frame($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Busy lasts exactly DATA_W cycles; a load during busy is dropped.
    do_load(2'b00, 16'd123, 32'h0);
    check("busy rise", 32'(busy), 32'd1);
    nb = 1;
    mode = 2'b01; bcd_in = 32'h11111111; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    if (busy) nb++;
    while (busy && nb < 40) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("busy cycles", 32'(nb), 32'd16);
    check_frame("ignored load", f123);

    // Error overlay appears the next cycle and releases back to the frame.
    do_load(2'b01, 16'd0, 32'h00123045);
    repeat (11) @(negedge clk);
    error = 1'b1;
    @(negedge clk);
    d = digit_of(an_out);
    check("err first digit valid", 32'(d >= 0), 32'd1);
    if (d >= 0) check("err next cycle", 32'(seg_out), 32'(err_glyph(d)));
    check_frame("err frame", ferr);
    error = 1'b0;
    @(negedge clk);
    d = digit_of(an_out);
    if (d >= 0) check("err release", 32'(seg_out), 32'(fclk[d]));
    check_frame("restored", fclk);

    // Load in the same cycle as error: captured, but hidden until error falls.
    error = 1'b1;
    do_load(2'b01, 16'd0, 32'h99999999);
    check_frame("load+err", ferr);
    error = 1'b0;
    check_frame("load+err after", {8{7'h10}});

    // PWM: brightness 3 gives 4 of 8 cycles per slot.
    brightness = 3'd3;
    @(negedge clk);
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) if (!an_out[k]) cnt[k]++;
    end
    for (int k = 0; k < 8; k++) check($sformatf("pwm d%0d", k), 32'(cnt[k]), 32'd4);

    // Blink: anodes dark for 2 frames (128 cycles) out of every 4.
    brightness = 3'd7;
    blink_en = 1'b1;
    @(negedge clk);
    on_cnt = 0; run = 0; max_off = 0;
    for (int c = 0; c < 512; c++) begin
      @(negedge clk);
      if (an_out != 8'hFF) begin
        on_cnt++;
        run = 0;
      end else begin
        run++;
        if (run > max_off) max_off = run;
      end
    end
    check("blink on cycles", 32'(on_cnt), 32'd256);
    check("blink off run", 32'(max_off), 32'd128);
    blink_en = 1'b0;

    // Asynchronous reset mid-conversion.
    do_load(2'b00, 16'd123, 32'h0);
    repeat (4) @(negedge clk);
    check("pre-rst busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst seg", 32'(seg_out), 32'h7F);
    check("async rst an", 32'(an_out), 32'hFF);
    check("async rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("post-rst frame", blank);
    check("post-rst busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
